// File: rtl/muldiv_share_arbiter_if.sv
// Request/response bundle between two requesters, the result consumer and
// the shared mult/div arbiter.
//   master : requester/consumer side (drives requests and rsp_ready)
//   slave  : arbiter side (drives req_ready and the registered response)
// WIDTH is the per-requester operand width; buses carry {slice1, slice0}.
interface muldiv_share_arbiter_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_result;
  logic               rsp_div_by_zero;
  logic               busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_div_by_zero, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_div_by_zero, busy
  );
endinterface

// File: rtl/muldiv_share_arbiter.sv
// Shares one signed multiply/divide datapath between two requesters.
// Arbitrates in IDLE, latches the winner's operands, runs a fixed-length
// EXEC phase, then holds a registered, ID-tagged result until consumed.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of muldiv_share_arbiter_if (requests in, result out)
// Build option:
//   MULDIV_ARB_RR_EN defined   -> round-robin on ties (pointer flips to the
//                                 loser after every accept)
//   MULDIV_ARB_RR_EN undefined -> fixed priority, requester 0 wins ties
module muldiv_share_arbiter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  muldiv_share_arbiter_if.slave  bus
);
  localparam int unsigned RW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(EXEC_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [RW-1:0]    rsp_result_q, rsp_result_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic             busy_q, busy_d;

  logic [1:0]       grant_c;
  logic             grant_id_c;

`ifdef MULDIV_ARB_RR_EN
  logic             rr_ptr_q;
`endif

  // Arbitration: grants only in IDLE and never while reset is asserted
  always_comb begin
    grant_c = 2'b00;
`ifdef MULDIV_ARB_RR_EN
    if (&bus.req_valid) grant_c = rr_ptr_q ? 2'b10 : 2'b01;
    else                grant_c = bus.req_valid;
`else
    if (bus.req_valid[0])      grant_c = 2'b01;
    else if (bus.req_valid[1]) grant_c = 2'b10;
`endif
    if ((state_q != ST_IDLE) || !rst_n) grant_c = 2'b00;
    grant_id_c = grant_c[1];
  end

  assign bus.req_ready = grant_c;

`ifdef MULDIV_ARB_RR_EN
  // Preferred requester becomes the one that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_ptr_q <= 1'b0;
    else if (|grant_c) rr_ptr_q <= ~grant_id_c;
  end
`endif

  // Shared datapath on the latched operands
  logic signed [RW-1:0]    a_ext_c, b_ext_c, prod_c;
  logic signed [WIDTH-1:0] divisor_c, quot_c;
  logic                    b_zero_c;
  logic [RW-1:0]           result_c;

  always_comb begin
    a_ext_c   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q});
    b_ext_c   = $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_c    = a_ext_c * b_ext_c;
    b_zero_c  = (b_q == '0);
    // Substitute 1 for a zero divisor so the divider never sees 0
    divisor_c = b_zero_c ? $signed(WIDTH'(1)) : $signed(b_q);
    quot_c    = $signed(a_q) / divisor_c;
    // Most-negative / -1 wraps back to most-negative
    if ((a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) quot_c = $signed(a_q);
    if (!op_q)         result_c = prod_c;
    else if (b_zero_c) result_c = '0;
    else               result_c = {{WIDTH{quot_c[WIDTH-1]}}, quot_c};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_dbz_d    = rsp_dbz_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant_c) begin
          op_d    = bus.req_op[grant_id_c];
          id_d    = grant_id_c;
          a_d     = grant_id_c ? bus.req_a[RW-1:WIDTH] : bus.req_a[WIDTH-1:0];
          b_d     = grant_id_c ? bus.req_b[RW-1:WIDTH] : bus.req_b[WIDTH-1:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Count preloads to 0 on accept so the response lands EXEC_CYCLES+1 edges later
        if (cnt_q == CNT_W'(EXEC_CYCLES)) begin
          rsp_result_d = result_c;
          rsp_dbz_d    = op_q & b_zero_c;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          cnt_d        = '0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_dbz_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_dbz_q    <= rsp_dbz_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_result      = rsp_result_q;
  assign bus.rsp_div_by_zero = rsp_dbz_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_muldiv_share_arbiter.sv
// Scoreboard bench for muldiv_share_arbiter: a driver predicts grants and
// pushes expected responses; a monitor pops and compares on each response.
module tb_muldiv_share_arbiter;
  localparam int unsigned W    = 8;
  localparam int unsigned EXEC = 2;
`ifdef MULDIV_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_share_arbiter_if #(.WIDTH(W)) bus_if ();
  muldiv_share_arbiter #(.WIDTH(W), .EXEC_CYCLES(EXEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    bit          id;
    logic [15:0] res;
    bit          dbz;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          cyc      = 0;
  bit          pend_v[2];
  bit          pend_op[2];
  logic [7:0]  pend_a[2];
  logic [7:0]  pend_b[2];
  bit          pref     = 1'b0;
  bit          inflight = 1'b0;
  int          rdy_pct  = 100;
  int          hold_cnt = 0;
  bit          last_id;
  logic [15:0] last_res;
  bit          last_dbz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference arithmetic using plain integer math
  function automatic void ref_model(input bit op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [15:0] res, output bit dbz);
    int ai, bi, r;
    ai  = $signed(a);
    bi  = $signed(b);
    dbz = 1'b0;
    if (!op)          r = ai * bi;
    else if (bi == 0) begin r = 0; dbz = 1'b1; end
    else begin
      r = ai / bi;
      if (r > 127) r -= 256;
    end
    res = 16'(r);
  endfunction

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(5))
      0:       return 8'h80;
      1:       return 8'hFF;
      2:       return 8'h00;
      3:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // One driver cycle: update requests, predict and check grant, record accept
  task automatic drive_cycle(input int new_pct, input int wd_pct);
    logic [1:0]  exp_g;
    int          g;
    exp_t        e;
    logic [15:0] r;
    bit          z;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pend_v[i] && ($urandom_range(99) < wd_pct)) pend_v[i] = 1'b0;
      else if (!pend_v[i] && ($urandom_range(99) < new_pct)) begin
        pend_v[i]  = 1'b1;
        pend_op[i] = 1'($urandom);
        pend_a[i]  = pick_operand();
        pend_b[i]  = pick_operand();
      end
    end
    bus_if.req_valid = {pend_v[1], pend_v[0]};
    bus_if.req_op    = {pend_op[1], pend_op[0]};
    bus_if.req_a     = {pend_a[1], pend_a[0]};
    bus_if.req_b     = {pend_b[1], pend_b[0]};
    #1;
    exp_g = 2'b00;
    if (!inflight) begin
      if (pend_v[0] && pend_v[1]) exp_g = (RR_EN && pref) ? 2'b10 : 2'b01;
      else                        exp_g = {pend_v[1], pend_v[0]};
    end
    check("req_ready", 32'(bus_if.req_ready), 32'(exp_g));
    if (exp_g != 2'b00) begin
      g = exp_g[1] ? 1 : 0;
      ref_model(pend_op[g], pend_a[g], pend_b[g], r, z);
      e.id = g[0]; e.res = r; e.dbz = z; e.acc = cyc + 1;
      exp_q.push_back(e);
      grant_log.push_back(g);
      inflight  = 1'b1;
      pref      = ~g[0];
      pend_v[g] = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend_v[0] || pend_v[1] || inflight || exp_q.size() != 0) && n < budget) begin
      drive_cycle(0, 0);
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic do_op(input int id, input bit op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] xres, input bit xdbz, input string name);
    pend_v[id] = 1'b1; pend_op[id] = op; pend_a[id] = a; pend_b[id] = b;
    drain(40);
    check({name, "_id"},  32'(last_id),  32'(id));
    check({name, "_res"}, 32'(last_res), 32'(xres));
    check({name, "_dbz"}, 32'(last_dbz), 32'(xdbz));
  endtask

  task automatic model_reset();
    exp_q.delete();
    inflight = 1'b0;
    pref     = 1'b0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
  endtask

  // Monitor: latency, stability while stalled, scoreboard pop on handshake
  initial begin : monitor
    bit          prev_v = 1'b0;
    bit          h_id;
    logic [15:0] h_res;
    bit          h_dbz;
    bus_if.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (bus_if.rsp_valid) begin
        check("busy_in_resp", 32'(bus_if.busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("rsp_without_request", 32'(bus_if.rsp_valid), 32'd0);
        end else begin
          if (!prev_v) check("latency", 32'(cyc - exp_q[0].acc), 32'(EXEC + 1));
          else begin
            check("stable_id",  32'(bus_if.rsp_id),          32'(h_id));
            check("stable_res", 32'(bus_if.rsp_result),      32'(h_res));
            check("stable_dbz", 32'(bus_if.rsp_div_by_zero), 32'(h_dbz));
          end
          h_id  = bus_if.rsp_id;
          h_res = bus_if.rsp_result;
          h_dbz = bus_if.rsp_div_by_zero;
          if (hold_cnt > 0) begin
            bus_if.rsp_ready = 1'b0;
            hold_cnt--;
          end else begin
            bus_if.rsp_ready = ($urandom_range(99) < rdy_pct);
          end
          if (bus_if.rsp_ready) begin
            check("rsp_id",  32'(bus_if.rsp_id),          32'(exp_q[0].id));
            check("rsp_res", 32'(bus_if.rsp_result),      32'(exp_q[0].res));
            check("rsp_dbz", 32'(bus_if.rsp_div_by_zero), 32'(exp_q[0].dbz));
            last_id  = bus_if.rsp_id;
            last_res = bus_if.rsp_result;
            last_dbz = bus_if.rsp_div_by_zero;
            void'(exp_q.pop_front());
            inflight = 1'b0;
          end
        end
        prev_v = bus_if.rsp_valid && !bus_if.rsp_ready;
      end else begin
        bus_if.rsp_ready = ($urandom_range(99) < rdy_pct);
        prev_v = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : main
    rst_n = 1'b0;
    bus_if.req_valid = 2'b00;
    bus_if.req_op    = 2'b00;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    model_reset();
    #1;
    check("rst_req_ready",  32'(bus_if.req_ready),       32'd0);
    check("rst_rsp_valid",  32'(bus_if.rsp_valid),       32'd0);
    check("rst_rsp_id",     32'(bus_if.rsp_id),          32'd0);
    check("rst_rsp_result", 32'(bus_if.rsp_result),      32'd0);
    check("rst_dbz",        32'(bus_if.rsp_div_by_zero), 32'd0);
    check("rst_busy",       32'(bus_if.busy),            32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both requesters valid continuously for four grants
    grant_log.delete();
    pend_v[0] = 1'b1; pend_op[0] = 1'b0; pend_a[0] = 8'd3; pend_b[0] = 8'd5;
    pend_v[1] = 1'b1; pend_op[1] = 1'b1; pend_a[1] = 8'd50; pend_b[1] = 8'd7;
    for (int n = 0; n < 80 && grant_log.size() < 4; n++) drive_cycle(100, 0);
    drain(60);
    check("tie_grant_count", 32'(grant_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("tie_grant_id", 32'(grant_log[i]), RR_EN ? 32'(i % 2) : 32'd0);

    do_op(0, 1'b0, 8'hFB, 8'h07, 16'hFFDD, 1'b0, "mul_m5x7");
    do_op(1, 1'b1, 8'h9C, 8'h07, 16'hFFF2, 1'b0, "div_m100_7");
    do_op(1, 1'b1, 8'h80, 8'hFF, 16'hFF80, 1'b0, "div_min_m1");
    do_op(0, 1'b1, 8'd42, 8'h00, 16'h0000, 1'b1, "div_by_zero");
    do_op(0, 1'b0, 8'd42, 8'h00, 16'h0000, 1'b0, "mul_by_zero");

    // Consumer stalls five cycles while the other requester waits
    hold_cnt = 5;
    pend_v[0] = 1'b1; pend_op[0] = 1'b0; pend_a[0] = 8'd3; pend_b[0] = 8'd4;
    for (int n = 0; n < 20 && !inflight; n++) drive_cycle(0, 0);
    pend_v[1] = 1'b1; pend_op[1] = 1'b1; pend_a[1] = 8'd9; pend_b[1] = 8'd2;
    drain(60);
    check("stall_consumed", 32'(hold_cnt), 32'd0);

    // Randomized traffic with stalls and withdrawn requests
    rdy_pct = 70;
    for (int n = 0; n < 400; n++) drive_cycle(35, 5);
    rdy_pct = 100;
    drain(200);

    // Reset during EXEC discards the operation
    pend_v[0] = 1'b1; pend_op[0] = 1'b0; pend_a[0] = 8'd6; pend_b[0] = 8'd7;
    for (int n = 0; n < 20 && !inflight; n++) drive_cycle(0, 0);
    drive_cycle(0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus_if.req_valid = 2'b11;
    #1;
    check("mid_rst_req_ready",  32'(bus_if.req_ready),       32'd0);
    check("mid_rst_rsp_valid",  32'(bus_if.rsp_valid),       32'd0);
    check("mid_rst_rsp_id",     32'(bus_if.rsp_id),          32'd0);
    check("mid_rst_rsp_result", 32'(bus_if.rsp_result),      32'd0);
    check("mid_rst_dbz",        32'(bus_if.rsp_div_by_zero), 32'd0);
    check("mid_rst_busy",       32'(bus_if.busy),            32'd0);
    bus_if.req_valid = 2'b00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive_cycle(0, 0);
      check("post_rst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      check("post_rst_idle",   32'(bus_if.busy),      32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
